// File: rtl/mem_if_pkg.sv
// rtl/mem_if_pkg.sv - shared data SRAM request types, constants and lane-merge helper
package mem_if_pkg;

    localparam logic [3:0] DSRAM_WE_NONE    = 4'h0;
    localparam logic [3:0] DSRAM_WE_WORD    = 4'hF;
    localparam int         MAX_READ_LATENCY = 4;

    typedef struct packed {
        logic        en;
        logic [3:0]  we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } dsram_req_t;

    // Replace the byte lanes selected by we with the matching lanes of wdata.
    function automatic logic [31:0] dsram_merge(input logic [31:0] old_word,
                                                input logic [31:0] wdata,
                                                input logic [3:0]  we);
        logic [31:0] merged;
        if (we == DSRAM_WE_WORD) begin
            merged = wdata;
        end else begin
            merged = old_word;
            for (int i = 0; i < 4; i++) begin
                if (we[i]) begin
                    merged[8*i +: 8] = wdata[8*i +: 8];
                end
            end
        end
        return merged;
    endfunction

endpackage

// File: rtl/data_sram_resp_if.sv
// rtl/data_sram_resp_if.sv - data SRAM request/response bus between EXE requester and RAM responder
interface data_sram_resp_if;

    logic        data_sram_en;
    logic [3:0]  data_sram_we;
    logic [31:0] data_sram_addr;
    logic [31:0] data_sram_wdata;
    logic [31:0] data_sram_rdata;
    logic        data_sram_rvalid;
    logic        data_sram_oor;

    modport master (
        output data_sram_en, data_sram_we, data_sram_addr, data_sram_wdata,
        input  data_sram_rdata, data_sram_rvalid, data_sram_oor
    );

    modport slave (
        input  data_sram_en, data_sram_we, data_sram_addr, data_sram_wdata,
        output data_sram_rdata, data_sram_rvalid, data_sram_oor
    );

endinterface

// File: rtl/dsram_rd_pipe.sv
// rtl/dsram_rd_pipe.sv - valid/data delay line for read results; last stage holds its data between results
module dsram_rd_pipe #(
    parameter int DEPTH = 1,
    parameter int W     = 32
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic         i_valid,
    input  logic [W-1:0] i_data,
    output logic         o_valid,
    output logic [W-1:0] o_data
);

    logic [DEPTH-1:0] r_valid;
    logic [W-1:0]     r_data [DEPTH];

    // Shift valids every cycle; data only moves alongside a valid so the tail keeps the last result.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_valid <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_data[i] <= '0;
            end
        end else begin
            r_valid[0] <= i_valid;
            if (i_valid) begin
                r_data[0] <= i_data;
            end
            for (int i = 1; i < DEPTH; i++) begin
                r_valid[i] <= r_valid[i-1];
                if (r_valid[i-1]) begin
                    r_data[i] <= r_data[i-1];
                end
            end
        end
    end

    assign o_valid = r_valid[DEPTH-1];
    assign o_data  = r_data[DEPTH-1];

endmodule

// File: rtl/data_sram_resp.sv
// rtl/data_sram_resp.sv - synchronous data RAM responder; optional DATA_SRAM_PERF_EN adds read/write counters
module data_sram_resp
    import mem_if_pkg::*;
#(
    parameter int          ADDR_W       = 16,
    parameter int          READ_LATENCY = 1,
    parameter logic [31:0] BASE_ADDR    = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              resetn,
    data_sram_resp_if.slave   bus
`ifdef DATA_SRAM_PERF_EN
    ,
    output logic [31:0]       perf_rd_cnt,
    output logic [31:0]       perf_wr_cnt
`endif
);

    localparam int          DEPTH = 2 ** ADDR_W;
    localparam logic [32:0] SPAN  = 33'(1) << (ADDR_W + 2);

    if (READ_LATENCY < 1 || READ_LATENCY > MAX_READ_LATENCY) begin : g_bad_latency
        $error("data_sram_resp: READ_LATENCY must be within 1..4");
    end

    dsram_req_t        w_req;
    logic [31:0]       w_off;
    logic              w_in_range;
    logic [ADDR_W-1:0] w_idx;
    logic              w_rd;
    logic              w_wr;
    logic [31:0]       w_rd_word;
    logic              w_pipe_valid;
    logic [31:0]       w_pipe_data;

    logic [31:0]       r_mem [DEPTH];
    logic              r_oor;

    assign w_req = '{en:    bus.data_sram_en,
                     we:    bus.data_sram_we,
                     addr:  bus.data_sram_addr,
                     wdata: bus.data_sram_wdata};

    // Offset below BASE_ADDR wraps to a huge unsigned value and so lands out of range.
    assign w_off      = w_req.addr - BASE_ADDR;
    assign w_in_range = {1'b0, w_off} < SPAN;
    assign w_idx      = w_off[ADDR_W+1:2];
    assign w_rd       = w_req.en && (w_req.we == DSRAM_WE_NONE);
    assign w_wr       = w_req.en && (w_req.we != DSRAM_WE_NONE);
    assign w_rd_word  = w_in_range ? r_mem[w_idx] : 32'h0;

    // Byte-masked write; storage is never cleared, only gated off while in reset.
    always_ff @(posedge clk) begin
        if (resetn && w_wr && w_in_range) begin
            r_mem[w_idx] <= dsram_merge(r_mem[w_idx], w_req.wdata, w_req.we);
        end
    end

    // Out-of-range flag for the request accepted at the previous edge.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_oor <= 1'b0;
        end else begin
            r_oor <= w_req.en && !w_in_range;
        end
    end

    dsram_rd_pipe #(
        .DEPTH (READ_LATENCY),
        .W     (32)
    ) u_rd_pipe (
        .clk     (clk),
        .resetn  (resetn),
        .i_valid (w_rd),
        .i_data  (w_rd_word),
        .o_valid (w_pipe_valid),
        .o_data  (w_pipe_data)
    );

    assign bus.data_sram_rdata  = w_pipe_data;
    assign bus.data_sram_rvalid = w_pipe_valid;
    assign bus.data_sram_oor    = r_oor;

`ifdef DATA_SRAM_PERF_EN
    logic [31:0] r_perf_rd_cnt;
    logic [31:0] r_perf_wr_cnt;

    // Free-running request counters, wrapping at 2**32.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_perf_rd_cnt <= '0;
            r_perf_wr_cnt <= '0;
        end else begin
            if (w_rd) begin
                r_perf_rd_cnt <= r_perf_rd_cnt + 32'd1;
            end
            if (w_wr) begin
                r_perf_wr_cnt <= r_perf_wr_cnt + 32'd1;
            end
        end
    end

    assign perf_rd_cnt = r_perf_rd_cnt;
    assign perf_wr_cnt = r_perf_wr_cnt;
`endif

endmodule

// File: tb/tb_data_sram_resp.sv
// tb/tb_data_sram_resp.sv - self-checking bench for data_sram_resp at read latencies 1, 2 and 3
module tb_data_sram_resp;

    localparam int MAXC = 1024;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        en = 1'b0;
    logic [3:0]  we = 4'h0;
    logic [31:0] addr = 32'h0;
    logic [31:0] wdata = 32'h0;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    data_sram_resp_if if1 ();
    data_sram_resp_if if2 ();
    data_sram_resp_if if3 ();

    assign if1.data_sram_en = en;  assign if1.data_sram_we = we;
    assign if1.data_sram_addr = addr;  assign if1.data_sram_wdata = wdata;
    assign if2.data_sram_en = en;  assign if2.data_sram_we = we;
    assign if2.data_sram_addr = addr;  assign if2.data_sram_wdata = wdata;
    assign if3.data_sram_en = en;  assign if3.data_sram_we = we;
    assign if3.data_sram_addr = addr;  assign if3.data_sram_wdata = wdata;

    logic [31:0] o_rdata [1:3];
    logic        o_rv    [1:3];
    logic        o_oor   [1:3];
    logic [31:0] p_rd    [1:3];
    logic [31:0] p_wr    [1:3];

    assign o_rdata[1] = if1.data_sram_rdata; assign o_rv[1] = if1.data_sram_rvalid; assign o_oor[1] = if1.data_sram_oor;
    assign o_rdata[2] = if2.data_sram_rdata; assign o_rv[2] = if2.data_sram_rvalid; assign o_oor[2] = if2.data_sram_oor;
    assign o_rdata[3] = if3.data_sram_rdata; assign o_rv[3] = if3.data_sram_rvalid; assign o_oor[3] = if3.data_sram_oor;

`ifndef DATA_SRAM_PERF_EN
    assign p_rd[1] = 32'h0; assign p_rd[2] = 32'h0; assign p_rd[3] = 32'h0;
    assign p_wr[1] = 32'h0; assign p_wr[2] = 32'h0; assign p_wr[3] = 32'h0;
`endif

    data_sram_resp #(.ADDR_W(4), .READ_LATENCY(1), .BASE_ADDR(32'h0)) dut1 (
        .clk(clk), .resetn(resetn), .bus(if1.slave)
`ifdef DATA_SRAM_PERF_EN
        , .perf_rd_cnt(p_rd[1]), .perf_wr_cnt(p_wr[1])
`endif
    );
    data_sram_resp #(.ADDR_W(4), .READ_LATENCY(2), .BASE_ADDR(32'h0)) dut2 (
        .clk(clk), .resetn(resetn), .bus(if2.slave)
`ifdef DATA_SRAM_PERF_EN
        , .perf_rd_cnt(p_rd[2]), .perf_wr_cnt(p_wr[2])
`endif
    );
    data_sram_resp #(.ADDR_W(4), .READ_LATENCY(3), .BASE_ADDR(32'h0)) dut3 (
        .clk(clk), .resetn(resetn), .bus(if3.slave)
`ifdef DATA_SRAM_PERF_EN
        , .perf_rd_cnt(p_rd[3]), .perf_wr_cnt(p_wr[3])
`endif
    );

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s[lat%0d] at %0t: got %h expected %h", name, idx, $time, act, exp);
        end
    endtask

    // Behavioural model: per-edge history of reads and resets; a result for latency L
    // emerges L-1 edges after its issuing edge unless a reset edge falls in between.
    logic [31:0] m_mem  [0:15];
    bit          h_rst  [0:MAXC-1];
    bit          h_rv   [0:MAXC-1];
    logic [31:0] h_rd   [0:MAXC-1];
    int          n = 0;
    logic [31:0] e_rdata [1:3];
    bit          e_rv    [1:3];
    bit          e_oor;
    int unsigned e_rd_cnt, e_wr_cnt;

    always @(posedge clk) begin : model
        logic [31:0] off;
        bit inr, ok;
        int m;
        if (n >= MAXC) begin
            $display("FAIL model_history: cycle budget %0d exceeded", MAXC);
            $fatal(1, "history overflow");
        end
        off = addr - 32'h0;
        inr = off < 32'd64;
        h_rst[n] = !resetn;
        h_rv[n]  = 1'b0;
        h_rd[n]  = 32'h0;
        if (!resetn) begin
            e_oor = 1'b0; e_rd_cnt = 0; e_wr_cnt = 0;
        end else begin
            e_oor = en && !inr;
            if (en && we == 4'h0) begin
                h_rv[n] = 1'b1;
                h_rd[n] = inr ? m_mem[off[5:2]] : 32'h0;
                e_rd_cnt++;
            end else if (en) begin
                if (inr) begin
                    for (int i = 0; i < 4; i++)
                        if (we[i]) m_mem[off[5:2]][8*i +: 8] = wdata[8*i +: 8];
                end
                e_wr_cnt++;
            end
        end
        for (int L = 1; L <= 3; L++) begin
            if (!resetn) begin
                e_rv[L] = 1'b0; e_rdata[L] = 32'h0;
            end else begin
                m  = n - L + 1;
                ok = (m >= 0) && h_rv[m];
                for (int k = m + 1; k <= n; k++)
                    if (k >= 0 && h_rst[k]) ok = 1'b0;
                e_rv[L] = ok;
                if (ok) e_rdata[L] = h_rd[m];
            end
        end
        n++;
    end

    // Compare all three instances against the model every cycle, away from the active edge.
    always @(negedge clk) begin
        if (n > 0) begin
            for (int L = 1; L <= 3; L++) begin
                chk("rvalid", L, {31'h0, o_rv[L]}, {31'h0, e_rv[L]});
                chk("rdata",  L, o_rdata[L], e_rdata[L]);
                chk("oor",    L, {31'h0, o_oor[L]}, {31'h0, e_oor});
`ifdef DATA_SRAM_PERF_EN
                chk("perf_rd", L, p_rd[L], e_rd_cnt);
                chk("perf_wr", L, p_wr[L], e_wr_cnt);
`endif
            end
        end
    end

    task automatic cyc(input bit rn, input bit e, input logic [3:0] w, input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        resetn = rn; en = e; we = w; addr = a; wdata = d;
    endtask
    task automatic wr(input logic [31:0] a, input logic [3:0] w, input logic [31:0] d); cyc(1, 1, w, a, d); endtask
    task automatic rd(input logic [31:0] a); cyc(1, 1, 4'h0, a, 32'h0); endtask
    task automatic idle(); cyc(1, 0, 4'hF, 32'h0, 32'hFFFF_FFFF); endtask

    typedef struct { bit e; logic [3:0] w; logic [31:0] a; logic [31:0] d; } op_t;
    op_t mix [8] = '{
        '{1, 4'h0, 32'h04, 32'h0}, '{1, 4'h3, 32'h04, 32'h0000_A5A5},
        '{1, 4'h0, 32'h04, 32'h0}, '{1, 4'h0, 32'h3C, 32'h0},
        '{1, 4'h8, 32'h3C, 32'h7700_0000}, '{1, 4'h0, 32'h3E, 32'h0},
        '{1, 4'h0, 32'hFFFF_FFFC, 32'h0}, '{0, 4'h0, 32'h08, 32'h0}
    };

    initial begin
        repeat (3) cyc(0, 0, 4'h0, 32'h0, 32'h0);
        chk("lit_rst_rvalid", 1, {31'h0, o_rv[1]}, 32'h0);
        chk("lit_rst_rdata",  3, o_rdata[3], 32'h0);
        chk("lit_rst_oor",    2, {31'h0, o_oor[2]}, 32'h0);

        for (int i = 0; i < 16; i++) wr(32'(4 * i), 4'hF, 32'(i + 1));

        wr(32'h10, 4'hF, 32'hDEAD_BEEF);
        rd(32'h10);
        idle(); chk("lit_word_rv", 1, {31'h0, o_rv[1]}, 32'h1);
                chk("lit_word", 1, o_rdata[1], 32'hDEAD_BEEF);
        idle(); chk("lit_word", 2, o_rdata[2], 32'hDEAD_BEEF);
        idle(); chk("lit_word", 3, o_rdata[3], 32'hDEAD_BEEF);

        wr(32'h20, 4'hF, 32'h1122_3344);
        wr(32'h20, 4'b0101, 32'hAABB_CCDD);
        rd(32'h23);
        idle(); chk("lit_lanes", 1, o_rdata[1], 32'h11BB_33DD);

        rd(32'h0); rd(32'h4); rd(32'h8);
        chk("lit_lat3_early", 3, {31'h0, o_rv[3]}, 32'h0);
        idle(); chk("lit_lat3_d0", 3, o_rdata[3], 32'h1);
        idle(); chk("lit_lat3_d1", 3, o_rdata[3], 32'h2);
        idle(); chk("lit_lat3_d2", 3, o_rdata[3], 32'h3);

        rd(32'h0); wr(32'h0, 4'hF, 32'h9); idle(); idle();
        chk("lit_inflight", 3, o_rdata[3], 32'h1);
        rd(32'h0); idle(); chk("lit_after_wr", 1, o_rdata[1], 32'h9);

        rd(32'h40);
        idle(); chk("lit_oor_rdata", 1, o_rdata[1], 32'h0);
                chk("lit_oor_flag", 1, {31'h0, o_oor[1]}, 32'h1);
        idle(); chk("lit_oor_clear", 1, {31'h0, o_oor[1]}, 32'h0);
        wr(32'h40, 4'hF, 32'hFFFF_FFFF);
        idle(); chk("lit_oor_wr", 2, {31'h0, o_oor[2]}, 32'h1);
        rd(32'h0); idle(); chk("lit_mem0_kept", 1, o_rdata[1], 32'h9);

        rd(32'h4);
        cyc(0, 1, 4'hF, 32'h4, 32'h55);
        idle(); chk("lit_rst_drop_rv", 2, {31'h0, o_rv[2]}, 32'h0);
                chk("lit_rst_drop_d", 2, o_rdata[2], 32'h0);
        idle(); chk("lit_rst_drop_rv2", 2, {31'h0, o_rv[2]}, 32'h0);
        rd(32'h4); idle(); idle();
        chk("lit_post_rst", 2, o_rdata[2], 32'h2);

        foreach (mix[i]) cyc(1, mix[i].e, mix[i].w, mix[i].a, mix[i].d);
        repeat (4) idle();

        cyc(0, 0, 4'h0, 32'h0, 32'h0);
        for (int i = 0; i < 5; i++) rd(32'(4 * i));
        for (int i = 0; i < 3; i++) wr(32'(4 * i), 4'hF, 32'(100 + i));
        idle(); idle(); idle();
`ifdef DATA_SRAM_PERF_EN
        chk("lit_perf_rd", 1, p_rd[1], 32'd5);
        chk("lit_perf_wr", 1, p_wr[1], 32'd3);
        cyc(0, 1, 4'h0, 32'h0, 32'h0);
        idle();
        chk("lit_perf_rd_rst", 1, p_rd[1], 32'd0);
        chk("lit_perf_wr_rst", 1, p_wr[1], 32'd0);
`endif
        repeat (4) idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
